// File: rtl/imem_arbiter_if.sv
// Bundle of requester, response and memory-port signals for imem_arbiter.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PC_W   = 20
);
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              cpu_run;

    logic              fetch_req;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_fault;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              dbg_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_done,
        input  fetch_req, fetch_pc,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output ld_ready, cpu_run,
        output fetch_gnt, fetch_valid, fetch_instr, fetch_fault,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_done,
        output fetch_req, fetch_pc,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  ld_ready, cpu_run,
        input  fetch_gnt, fetch_valid, fetch_instr, fetch_fault,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between boot loader, CPU fetch and debug.
// Optional: IMEM_ARB_WRITE_PROTECT_EN blocks debug writes in RUN and flags them on dbg_err.
module imem_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned PC_W       = 20,
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {ST_BOOT, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               fetch_fault_q, fetch_fault_d;
    logic               dbg_rvalid_q, dbg_rvalid_d;

    logic               ld_ready_c;
    logic               fetch_gnt_c;
    logic               dbg_gnt_c;
    logic               mem_en_c;
    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [31:0]        mem_wdata_c;
    logic               force_dbg_c;
    logic               fetch_bad_c;
    logic               fetch_valid_c;

    // Misaligned pc or any address bit above the memory's word range faults the fetch
    assign fetch_bad_c = (bus.fetch_pc[1:0] != 2'b00) ||
                         (|bus.fetch_pc[PC_W-1:ADDR_W+2]);

    always_comb begin
        state_d       = state_q;
        starve_d      = '0;
        ld_ready_c    = 1'b0;
        fetch_gnt_c   = 1'b0;
        dbg_gnt_c     = 1'b0;
        mem_en_c      = 1'b0;
        mem_we_c      = 1'b0;
        mem_addr_c    = '0;
        mem_wdata_c   = '0;
        force_dbg_c   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                ld_ready_c = 1'b1;
                if (bus.ld_valid) begin
                    mem_en_c    = 1'b1;
                    mem_we_c    = 1'b1;
                    mem_addr_c  = bus.ld_addr;
                    mem_wdata_c = bus.ld_data;
                end
                if (bus.ld_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                force_dbg_c = bus.dbg_req && (starve_q == CNT_W'(STARVE_MAX));
                if (bus.fetch_req && !force_dbg_c) begin
                    fetch_gnt_c = 1'b1;
                    if (!fetch_bad_c) begin
                        mem_en_c   = 1'b1;
                        mem_addr_c = bus.fetch_pc[ADDR_W+1:2];
                    end
                    // Debug lost this cycle: age it, saturating at the force threshold
                    if (bus.dbg_req) begin
                        starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q
                                                                    : starve_q + CNT_W'(1);
                    end
                end else if (bus.dbg_req) begin
                    dbg_gnt_c   = 1'b1;
                    mem_addr_c  = bus.dbg_addr;
                    mem_wdata_c = bus.dbg_wdata;
`ifdef IMEM_ARB_WRITE_PROTECT_EN
                    mem_en_c    = !bus.dbg_we;
                    mem_we_c    = 1'b0;
`else
                    mem_en_c    = 1'b1;
                    mem_we_c    = bus.dbg_we;
`endif
                end
            end
            default: state_d = ST_BOOT;
        endcase

        fetch_valid_d = fetch_gnt_c;
        fetch_fault_d = fetch_gnt_c && fetch_bad_c;
        dbg_rvalid_d  = dbg_gnt_c && !bus.dbg_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            starve_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
        end
    end

`ifdef IMEM_ARB_WRITE_PROTECT_EN
    logic dbg_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_err_q <= 1'b0;
        end else begin
            dbg_err_q <= dbg_gnt_c && bus.dbg_we;
        end
    end

    assign bus.dbg_err = dbg_err_q && !rst;
`else
    assign bus.dbg_err = 1'b0;
`endif

    // Responses are masked while rst is high so a read in flight never surfaces
    assign fetch_valid_c   = fetch_valid_q && !rst;
    assign bus.fetch_valid = fetch_valid_c;
    assign bus.fetch_fault = fetch_fault_q && !rst;
    assign bus.fetch_instr = !fetch_valid_c ? 32'h0 :
                             (fetch_fault_q ? NOP_WORD : bus.mem_rdata);
    assign bus.dbg_rvalid  = dbg_rvalid_q && !rst;
    assign bus.dbg_rdata   = (dbg_rvalid_q && !rst) ? bus.mem_rdata : 32'h0;

    assign bus.cpu_run     = (state_q == ST_RUN);
    assign bus.ld_ready    = ld_ready_c;
    assign bus.fetch_gnt   = fetch_gnt_c;
    assign bus.dbg_gnt     = dbg_gnt_c;
    assign bus.mem_en      = mem_en_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed stimulus plus a response scoreboard.
// Honours IMEM_ARB_WRITE_PROTECT_EN when compiled with the design.
module tb_imem_arbiter;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PC_W   = 20;
    localparam logic [31:0] NOP    = 32'h00000013;
`ifdef IMEM_ARB_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    typedef struct packed {
        logic        fault;
        logic [31:0] instr;
    } fexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

    imem_arbiter #(
        .ADDR_W(ADDR_W), .PC_W(PC_W), .STARVE_MAX(4), .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] boot    [4] = '{32'h00100313, 32'h00200393, 32'h007302B3, 32'h0000006F};
    fexp_t       fq[$];
    logic [31:0] dq[$];
    fexp_t       fe;
    logic [31:0] de;
    bit          pend_f = 1'b0;
    bit          pend_d = 1'b0;
    bit          pend_e = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic fexp_t exp_fetch(input logic [PC_W-1:0] pc);
        fexp_t r;
        logic  bad;
        bad     = (pc[1:0] != 2'b00) || (pc[PC_W-1:10] != '0);
        r.fault = bad;
        r.instr = bad ? NOP : ref_mem[pc[9:2]];
        return r;
    endfunction

    // Single-port synchronous memory with 1-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    // Scoreboard: push on grant, pop and compare on the following cycle
    always @(negedge clk) begin
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(pend_f && !rst));
        if (pend_f) begin
            fe = fq.pop_front();
            if (bus.fetch_valid && !rst) begin
                chk("fetch_fault", 32'(bus.fetch_fault), 32'(fe.fault));
                chk("fetch_instr", bus.fetch_instr, fe.instr);
            end
        end
        chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(pend_d && !rst));
        if (pend_d) begin
            de = dq.pop_front();
            if (bus.dbg_rvalid && !rst) chk("dbg_rdata", bus.dbg_rdata, de);
        end
        chk("dbg_err", 32'(bus.dbg_err), 32'(pend_e && !rst));
        chk("gnt_excl", 32'(bus.fetch_gnt & bus.dbg_gnt), 32'(0));

        pend_f = bus.fetch_gnt;
        if (pend_f) fq.push_back(exp_fetch(bus.fetch_pc));
        pend_d = bus.dbg_gnt && !bus.dbg_we;
        if (pend_d) dq.push_back(ref_mem[bus.dbg_addr]);
        pend_e = bus.dbg_gnt && bus.dbg_we && WP;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ld_done   = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

    initial begin
        logic [PC_W-1:0] bad_pc [2];
        bad_pc[0] = 20'h00002;
        bad_pc[1] = 20'h00400;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cpu_run",     32'(bus.cpu_run),     32'(0));
        chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'(0));
        chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'(0));
        chk("rst_dbg_rvalid",  32'(bus.dbg_rvalid),  32'(0));
        chk("rst_dbg_err",     32'(bus.dbg_err),     32'(0));
        chk("rst_fetch_instr", bus.fetch_instr,      32'h0);
        chk("rst_dbg_rdata",   bus.dbg_rdata,        32'h0);

        step();
        rst = 1'b0;
        #1;
        chk("boot_ready_idle", 32'(bus.ld_ready), 32'(1));
        chk("boot_men_idle",   32'(bus.mem_en),   32'(0));

        // Boot load with fetch and debug requesting; ld_done rides on the last write
        for (int i = 0; i < 4; i++) begin
            step();
            bus.ld_valid  = 1'b1;
            bus.ld_addr   = ADDR_W'(i);
            bus.ld_data   = boot[i];
            bus.ld_done   = (i == 3);
            bus.fetch_req = 1'b1;
            bus.dbg_req   = 1'b1;
            ref_mem[i]    = boot[i];
            #1;
            chk("boot_ready",  32'(bus.ld_ready),  32'(1));
            chk("boot_men",    32'(bus.mem_en),    32'(1));
            chk("boot_mwe",    32'(bus.mem_we),    32'(1));
            chk("boot_maddr",  32'(bus.mem_addr),  32'(i));
            chk("boot_mwdata", bus.mem_wdata,      boot[i]);
            chk("boot_fgnt",   32'(bus.fetch_gnt), 32'(0));
            chk("boot_dgnt",   32'(bus.dbg_gnt),   32'(0));
            chk("boot_cpurun", 32'(bus.cpu_run),   32'(0));
        end
        step();
        idle_inputs();
        #1;
        chk("run_cpu_run", 32'(bus.cpu_run),  32'(1));
        chk("run_ready",   32'(bus.ld_ready), 32'(0));

        // Loader traffic and ld_done in RUN are ignored
        step();
        bus.ld_valid = 1'b1;
        bus.ld_done  = 1'b1;
        bus.ld_addr  = 8'd7;
        #1;
        chk("run_ld_men", 32'(bus.mem_en), 32'(0));
        step();
        idle_inputs();
        #1;
        chk("run_stays", 32'(bus.cpu_run), 32'(1));

        // Back-to-back fetches
        for (int i = 0; i < 3; i++) begin
            step();
            bus.fetch_req = 1'b1;
            bus.fetch_pc  = PC_W'(4 * i);
            #1;
            chk("seq_fgnt",  32'(bus.fetch_gnt), 32'(1));
            chk("seq_men",   32'(bus.mem_en),    32'(1));
            chk("seq_maddr", 32'(bus.mem_addr),  32'(i));
        end
        step();
        idle_inputs();

        // Faulting fetches are granted but never touch memory
        for (int i = 0; i < 2; i++) begin
            step();
            bus.fetch_req = 1'b1;
            bus.fetch_pc  = bad_pc[i];
            #1;
            chk("fault_fgnt", 32'(bus.fetch_gnt), 32'(1));
            chk("fault_men",  32'(bus.mem_en),    32'(0));
        end
        step();
        idle_inputs();

        // Starvation: debug read forced through on the 5th contended cycle
        for (int c = 1; c <= 6; c++) begin
            step();
            bus.fetch_req = 1'b1;
            bus.fetch_pc  = 20'h0000C;
            bus.dbg_req   = 1'b1;
            bus.dbg_we    = 1'b0;
            bus.dbg_addr  = 8'd1;
            #1;
            chk("starve_fgnt", 32'(bus.fetch_gnt), 32'(c != 5));
            chk("starve_dgnt", 32'(bus.dbg_gnt),   32'(c == 5));
        end
        step();
        idle_inputs();

        // Debug write to address 0, then read it back and refetch it
        step();
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 8'd0;
        bus.dbg_wdata = 32'hDEADBEEF;
        if (!WP) ref_mem[0] = 32'hDEADBEEF;
        #1;
        chk("dwr_dgnt", 32'(bus.dbg_gnt), 32'(1));
        chk("dwr_men",  32'(bus.mem_en),  32'(!WP));
        chk("dwr_mwe",  32'(bus.mem_we),  32'(!WP));
        step();
        bus.dbg_we    = 1'b0;
        bus.dbg_wdata = '0;
        #1;
        chk("drd_dgnt", 32'(bus.dbg_gnt), 32'(1));
        chk("drd_men",  32'(bus.mem_en),  32'(1));
        step();
        idle_inputs();
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = '0;
        step();
        idle_inputs();

        // Reset while a fetch read is in flight
        step();
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 20'h00004;
        #1;
        chk("rstrd_fgnt", 32'(bus.fetch_gnt), 32'(1));
        step();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rstrd_fvalid", 32'(bus.fetch_valid), 32'(0));
        step();
        rst = 1'b0;
        #1;
        chk("rstrd_cpu_run", 32'(bus.cpu_run), 32'(0));
        bus.fetch_req = 1'b1;
        #1;
        chk("rstrd_boot_fgnt",  32'(bus.fetch_gnt), 32'(0));
        chk("rstrd_boot_ready", 32'(bus.ld_ready),  32'(1));
        step();
        idle_inputs();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
